// File: rtl/golay_pkg.sv
// Shared constants and syndrome computation for the extended Golay (24,12) code.
// Check bit i contributes 1<<i; data bit 12+j contributes parity column C[j].
package golay_pkg;

    localparam int unsigned CODE_W = 24;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned SYN_W  = 12;

    // Index j holds the column for data bit 12+j (C[0] = bit 12 ... C[11] = bit 23).
    localparam logic [SYN_W-1:0] C [DATA_W] = '{
        12'h7FF, 12'hDC5, 12'hB8B, 12'hF16,
        12'hE2D, 12'hC5B, 12'h8B7, 12'h96E,
        12'hADC, 12'hDB8, 12'hB71, 12'hEE2
    };

    function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] e);
        logic [SYN_W-1:0] s;
        s = e[SYN_W-1:0];
        for (int j = 0; j < int'(DATA_W); j++) begin
            if (e[SYN_W + j]) begin
                s ^= C[j];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/ram.sv
// Syndrome-to-error-pattern ROM for the Golay (24,12) decoder, registered output.
// Contents: every error pattern of weight <= 3 stored at its syndrome, all else zero.
module ram #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] output_reg
);
    import golay_pkg::*;

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] rom [Depth];

    function automatic logic [DATA_W-1:0] onehot(input int idx);
        return DATA_W'(1) << idx;
    endfunction

    // Inputs are all constants, so this folds to a fixed table at elaboration.
    always_comb begin
        rom = '{default: '0};
        for (int i = 0; i < int'(CODE_W); i++) begin
            rom[syndrome(onehot(i))] = onehot(i);
            for (int j = i + 1; j < int'(CODE_W); j++) begin
                rom[syndrome(onehot(i) | onehot(j))] = onehot(i) | onehot(j);
                for (int k = j + 1; k < int'(CODE_W); k++) begin
                    rom[syndrome(onehot(i) | onehot(j) | onehot(k))] =
                        onehot(i) | onehot(j) | onehot(k);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_reg <= '0;
        end else begin
            output_reg <= rom[address];
        end
    end

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for the Golay syndrome ROM: directed, exhaustive and decoder-level reads
// checked against a reference table enumerated level by level from weight-0 patterns.
module tb_ram;
    import golay_pkg::*;

    logic        clk;
    logic        rst;
    logic [11:0] address;
    logic [23:0] output_reg;

    ram dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .output_reg (output_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [23:0] exp;
        logic [23:0] recv;
        logic [23:0] cw;
        int          kind;  // 0 directed, 1 sweep, 2 decode
    } txn_t;

    txn_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          nz_count = 0;
    logic [23:0] model [logic [11:0]];

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] lookup(input logic [11:0] a);
        return model.exists(a) ? model[a] : 24'h0;
    endfunction

    task automatic issue(input logic [11:0] a, input logic [23:0] exp, input int kind,
                         input logic [23:0] recv, input logic [23:0] cw);
        txn_t t;
        @(negedge clk);
        address = a;
        t.addr = a; t.exp = exp; t.kind = kind; t.recv = recv; t.cw = cw;
        sb.push_back(t);
    endtask

    // Monitor: the ROM answers one edge after each issued address.
    initial begin
        txn_t t;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                t = sb.pop_front();
                case (t.kind)
                    0: check($sformatf("read_%h", t.addr), output_reg, t.exp);
                    1: begin
                        check($sformatf("sweep_%h", t.addr), output_reg, t.exp);
                        ok = (output_reg == 24'h0) ||
                             ($countones(output_reg) <= 3 && syndrome(output_reg) == t.addr);
                        check($sformatf("sweep_prop_%h", t.addr), {23'h0, ok}, 24'h1);
                        if (output_reg != 24'h0) nz_count++;
                    end
                    default: check($sformatf("decode_%h", t.addr), output_reg ^ t.recv, t.cw);
                endcase
            end
        end
    end

    logic [11:0] dir_addr [9] = '{12'h000, 12'h001, 12'h800, 12'hEE2, 12'h7FF,
                                   12'hEE3, 12'h26C, 12'h593, 12'h00F};
    logic [23:0] dir_exp  [9] = '{24'h000000, 24'h000001, 24'h000800, 24'h800000, 24'h001000,
                                   24'h800001, 24'hC01000, 24'hC00000, 24'h000000};

    initial begin
        logic [23:0] cur[$];
        logic [23:0] nxt[$];
        logic [23:0] last_exp;
        logic [23:0] cw, mask;
        logic [11:0] data;
        int          top;
        int          w;

        rst = 1'b1;
        address = 12'h001;

        // Reference table: grow weight-w patterns by appending a bit above the highest set one.
        cur.push_back(24'h0);
        model[12'h000] = 24'h0;
        for (int lvl = 1; lvl <= 3; lvl++) begin
            nxt.delete();
            foreach (cur[n]) begin
                top = -1;
                for (int b = 0; b < 24; b++) if (cur[n][b]) top = b;
                for (int b = top + 1; b < 24; b++) nxt.push_back(cur[n] | (24'h1 << b));
            end
            foreach (nxt[n]) model[syndrome(nxt[n])] = nxt[n];
            cur = nxt;
        end

        #1 check("rst_init", output_reg, 24'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        address = 12'h000;
        last_exp = 24'h0;

        // Directed reads; output must still show the previous result right after the change.
        for (int i = 0; i < 9; i++) begin
            issue(dir_addr[i], dir_exp[i], 0, 24'h0, 24'h0);
            #1 check($sformatf("hold_before_%h", dir_addr[i]), output_reg, last_exp);
            last_exp = dir_exp[i];
        end

        // Mid-cycle asynchronous reset.
        @(negedge clk);
        address = 12'h001;
        @(posedge clk);
        #1 check("pre_rst", output_reg, 24'h000001);
        #2 rst = 1'b1;
        #1 check("rst_async", output_reg, 24'h0);
        repeat (2) @(posedge clk);
        #1 check("rst_hold", output_reg, 24'h0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{addr: 12'h001, exp: 24'h000001, recv: 24'h0, cw: 24'h0, kind: 0});

        // Exhaustive back-to-back sweep.
        for (int a = 0; a < 4096; a++) begin
            issue(12'(a), lookup(12'(a)), 1, 24'h0, 24'h0);
        end
        repeat (2) @(posedge clk);
        #2 check("nonzero_count", 24'(nz_count), 24'd2324);

        // Decoder-level: random codeword, up to three flipped bits.
        for (int n = 0; n < 200; n++) begin
            data = 12'($urandom);
            cw = {data, syndrome({data, 12'h000})};
            w = $urandom_range(0, 3);
            mask = 24'h0;
            while ($countones(mask) < w) mask |= 24'h1 << $urandom_range(0, 23);
            issue(syndrome(cw ^ mask), mask, 2, cw ^ mask, cw);
        end

        repeat (3) @(posedge clk);
        #2 check("sb_empty", 24'(sb.size()), 24'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
